// File: rtl/morse_encoder_if.sv
// Letter request/status bundle between a Morse letter source and the encoder.
// The source drives the request side; the encoder drives tx/busy/done.
interface morse_if;
  logic       start;
  logic [2:0] len;
  logic [4:0] pattern;
  logic       abort;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (output start, len, pattern, abort, input  tx, busy, done);
  modport slave  (input  start, len, pattern, abort, output tx, busy, done);
endinterface

// File: rtl/morse_encoder.sv
// Sends one Morse letter (1..5 elements, LSB first) as timed tone on/off units.
// Dot = 1 unit, dash = 3 units, element gap = 1 unit, letter gap = 3 units.
module morse_encoder #(
`ifdef SIM
  parameter int unsigned      T_BIT  = 4,
  parameter logic [T_BIT-1:0] T_UNIT = 4'd2
`else
  parameter int unsigned      T_BIT  = 26,
  parameter logic [T_BIT-1:0] T_UNIT = 26'hBE_BC20
`endif
) (
  input  logic   clk,
  input  logic   n_rst,
  morse_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MARK, SPACE, LGAP, DONE} state_t;

  localparam logic [T_BIT-1:0] CYC_LAST = T_UNIT - T_BIT'(1);

  state_t           state_q, state_d;
  logic [T_BIT-1:0] cyc_q, cyc_d;
  logic [1:0]       unit_q, unit_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       len_q, len_d;
  logic [4:0]       pat_q, pat_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0] last_unit;
  logic       unit_end;
  logic       len_ok;

  assign len_ok = (bus.len != 3'd0) && (bus.len <= 3'd5);

  // Durations are counted in whole units so the cycle counter never needs 3*T_UNIT.
  always_comb begin
    last_unit = 2'd0;
    case (state_q)
      MARK:    last_unit = pat_q[idx_q] ? 2'd2 : 2'd0;
      LGAP:    last_unit = 2'd1;
      default: last_unit = 2'd0;
    endcase
  end

  assign unit_end = (cyc_q == CYC_LAST) && (unit_q == last_unit);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pat_d   = pat_q;
    if (cyc_q == CYC_LAST) begin
      cyc_d  = '0;
      unit_d = unit_q + 2'd1;
    end else begin
      cyc_d  = cyc_q + T_BIT'(1);
      unit_d = unit_q;
    end

    case (state_q)
      IDLE: begin
        cyc_d  = '0;
        unit_d = '0;
        if (bus.start && !bus.abort && len_ok) begin
          len_d   = bus.len;
          pat_d   = bus.pattern;
          idx_d   = 3'd0;
          state_d = MARK;
        end
      end
      MARK:  if (unit_end) state_d = SPACE;
      SPACE: begin
        if (unit_end) begin
          if (idx_q == len_q - 3'd1) begin
            state_d = LGAP;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = MARK;
          end
        end
      end
      LGAP:    if (unit_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && bus.abort) begin
      state_d = IDLE;
      idx_d   = 3'd0;
    end

    if (state_d != state_q) begin
      cyc_d  = '0;
      unit_d = '0;
    end

    tx_d   = (state_d == MARK);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      tx_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Directed waveform tables plus a randomized run against a letter-level model.
module tb_morse_encoder;

  localparam int TU = 2;

  logic clk;
  logic n_rst;
  morse_if bus();

  morse_encoder #(.T_BIT(4), .T_UNIT(4'd2)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input int id, input int cyc, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL vec%0d cycle %0d: tx/busy/done got %b want %b", id, cyc, got, want);
    end
  endtask

  function automatic logic [2:0] outs();
    return {bus.tx, bus.busy, bus.done};
  endfunction

  // Cycle masks: bit k is the expected value in cycle k (start sampled in cycle 0).
  typedef struct {
    logic [2:0]  len;
    logic [4:0]  pat;
    int          s2;    // ignored start (len 1, dash) while busy
    int          s3;    // restart with the primary letter
    int          ab;
    int          rs;
    int          ncyc;
    logic [31:0] tx;
    logic [31:0] busy;
    logic [31:0] done;
  } vec_t;

  vec_t tbl[11];

  // Letter-level reference: a queue of upcoming {tx,busy,done} per cycle.
  logic [2:0] m_cur;
  logic [2:0] m_q[$];

  task automatic model_edge(input logic rn, input logic st, input logic [2:0] ln,
                            input logic [4:0] pt, input logic ab);
    if (!rn) begin
      m_q.delete();
      m_cur = 3'b000;
    end else if (m_cur[1]) begin
      if (ab) begin
        m_q.delete();
        m_cur = 3'b000;
      end else begin
        m_cur = (m_q.size() > 0) ? m_q.pop_front() : 3'b000;
      end
    end else if (st && !ab && ln >= 1 && ln <= 5) begin
      for (int i = 0; i < int'(ln); i++) begin
        repeat ((pt[i] ? 3 : 1) * TU) m_q.push_back(3'b110);
        repeat (TU) m_q.push_back(3'b010);
      end
      repeat (2 * TU) m_q.push_back(3'b010);
      m_q.push_back(3'b011);
      m_cur = m_q.pop_front();
    end else begin
      m_cur = 3'b000;
    end
  endtask

  initial begin
    logic [2:0] w;
    logic       r_rn, r_st, r_ab;
    logic [2:0] r_ln;
    logic [4:0] r_pt;

    tbl[0]  = '{3'd2, 5'b00010, -1, -1, -1, -1, 20, 32'h7E6,     32'h3FFFE,   32'h20000};
    tbl[1]  = '{3'd1, 5'b00000, -1, -1, -1, -1, 12, 32'h6,       32'h3FE,     32'h200};
    tbl[2]  = '{3'd1, 5'b00001, -1, -1, -1, -1, 16, 32'h7E,      32'h3FFE,    32'h2000};
    tbl[3]  = '{3'd2, 5'b00010,  4, -1, -1, -1, 20, 32'h7E6,     32'h3FFFE,   32'h20000};
    tbl[4]  = '{3'd2, 5'b00010,  4, 18, -1, -1, 22, 32'h1807E6,  32'h7BFFFE,  32'h20000};
    tbl[5]  = '{3'd0, 5'b10101, -1, -1, -1, -1, 20, 32'h0,       32'h0,       32'h0};
    tbl[6]  = '{3'd6, 5'b10101, -1, -1, -1, -1, 20, 32'h0,       32'h0,       32'h0};
    tbl[7]  = '{3'd5, 5'b00000, -1, -1, -1, -1, 27, 32'h66666,   32'h3FFFFFE, 32'h2000000};
    tbl[8]  = '{3'd2, 5'b00010, -1, -1,  6, -1, 25, 32'h66,      32'h7E,      32'h0};
    tbl[9]  = '{3'd2, 5'b00010, -1,  9, -1,  8, 20, 32'hFCDE6,   32'h1FFDFE,  32'h0};
    tbl[10] = '{3'd2, 5'b00010, -1, -1,  0, -1, 10, 32'h0,       32'h0,       32'h0};

    n_rst = 1'b0;
    bus.start = 1'b0; bus.len = 3'd0; bus.pattern = 5'd0; bus.abort = 1'b0;

    for (int v = 0; v < 11; v++) begin
      n_rst = 1'b0;
      bus.start = 1'b1; bus.len = 3'd1; bus.pattern = 5'd1; bus.abort = 1'b0;
      @(posedge clk); #1;
      chk(v, 0, outs(), 3'b000);
      for (int c = 0; c < tbl[v].ncyc; c++) begin
        n_rst     = (c != tbl[v].rs);
        bus.abort = (c == tbl[v].ab);
        bus.start = (c == 0) || (c == tbl[v].s2) || (c == tbl[v].s3);
        if (c == tbl[v].s2) begin
          bus.len = 3'd1; bus.pattern = 5'b00001;
        end else begin
          bus.len = tbl[v].len; bus.pattern = tbl[v].pat;
        end
        @(posedge clk); #1;
        w = {tbl[v].tx[c+1], tbl[v].busy[c+1], tbl[v].done[c+1]};
        chk(v, c + 1, outs(), w);
      end
    end

    // Randomized run against the reference model.
    n_rst = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    @(posedge clk); #1;
    model_edge(1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
    chk(100, 0, outs(), m_cur);
    for (int c = 1; c <= 4000; c++) begin
      r_rn = ($urandom_range(299) != 0);
      r_st = ($urandom_range(3) == 0);
      r_ln = 3'($urandom_range(7));
      r_pt = 5'($urandom);
      r_ab = ($urandom_range(79) == 0);
      n_rst = r_rn; bus.start = r_st; bus.len = r_ln; bus.pattern = r_pt; bus.abort = r_ab;
      @(posedge clk); #1;
      model_edge(r_rn, r_st, r_ln, r_pt, r_ab);
      chk(100, c, outs(), m_cur);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_encoder.md
MORSE_ENCODER -- requirements
Module: morse_encoder

Parameters
REQ-001 The block SHALL have parameter T_BIT, default 26 (4 when SIM is defined), the width of the unit-time counter.
REQ-002 The block SHALL have parameter T_UNIT, default 26'hBE_BC20 (0.25 s at 50 MHz; 4'd2 when SIM is defined), the length of one Morse unit in clk cycles; legal range is T_UNIT >= 1.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port n_rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: a request to send one letter; it is sampled only while busy=0.
REQ-006 The block SHALL have port len, input, 3 bits: the number of elements in the letter; legal values are 1..5.
REQ-007 The block SHALL have port pattern, input, 5 bits: the element code, where bit i is element i (1 = dash, 0 = dot), sent starting at bit 0.
REQ-008 The block SHALL have port abort, input, 1 bit: a synchronous cancel of the letter in progress.
REQ-009 The block SHALL have port tx, output, 1 bit: the registered LED/buzzer drive (1 = tone on).
REQ-010 The block SHALL have port busy, output, 1 bit: registered; it is 1 while a letter is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: registered; it is a one-cycle pulse marking the end of a letter.

Function
REQ-012 The block SHALL implement the states IDLE, MARK, SPACE, LGAP and DONE.
REQ-013 In IDLE, when start=1, len is in 1..5 and abort=0, the block SHALL latch len and pattern, set idx=0, enter MARK, and set tx=1 and busy=1 from the next cycle.
REQ-014 In IDLE, when start=1 and len is 0, 6 or 7, the block SHALL ignore the request: no state change, tx=0, busy=0, and no done pulse.
REQ-015 The block SHALL ignore start, len and pattern whenever busy=1; the latched values are held unchanged for the whole letter.
REQ-016 In MARK, tx SHALL be 1 for exactly T_UNIT cycles when pattern[idx]=0 and 3*T_UNIT cycles when pattern[idx]=1, after which the state becomes SPACE.
REQ-017 In SPACE, tx SHALL be 0 for exactly T_UNIT cycles; the block then goes to LGAP if idx = len-1, else it increments idx and returns to MARK.
REQ-018 In LGAP, tx SHALL be 0 for exactly 2*T_UNIT cycles (the letter gap totals 3 units including the last SPACE), after which the state becomes DONE.
REQ-019 DONE SHALL last one cycle with done=1, busy=1 and tx=0; the state then becomes IDLE with busy=0.
REQ-020 Timing SHALL use a T_BIT-bit cycle counter running 0..T_UNIT-1 plus a 2-bit unit counter running 0..units-1; both counters clear on every state change, and no counter is ever compared against 3*T_UNIT.
REQ-021 When abort=1 in any state other than IDLE, the next cycle SHALL be IDLE with tx=0, busy=0, done=0 and counters cleared, and no done pulse is produced; abort in IDLE has no effect.
REQ-022 When abort=1 and start=1 in the same IDLE cycle, abort SHALL win and the start is dropped.
REQ-023 The total letter time from the first tx=1 cycle to the done cycle (exclusive) SHALL be (sum of mark units + len + 2)*T_UNIT cycles.

Reset
REQ-024 When n_rst=0 at a rising clk edge, the block SHALL enter IDLE with tx=0, busy=0, done=0, idx=0, both counters at 0, and the latched len/pattern at 0.
REQ-025 Reset SHALL take priority over abort and start, and SHALL apply even mid-letter with no done pulse produced.
REQ-026 The first start SHALL be accepted in the first cycle with n_rst=1.

Verification (SIM, T_UNIT=2; start sampled at cycle 0)
REQ-027 The bench SHALL check 'A' (len=2, pattern=5'b00010): tx=1 in cycles 1-2 and 5-10, tx=0 in cycles 3-4 and 11-16, done=1 only in cycle 17, and busy=1 in cycles 1-17.
REQ-028 The bench SHALL check 'E' (len=1, pattern=0) giving tx=1 in cycles 1-2 and done in cycle 9, and 'T' (len=1, pattern=1) giving tx=1 in cycles 1-6 and done in cycle 13.
REQ-029 The bench SHALL check that 'A' with a second start pulse (len=1, pattern=1) at cycle 4 produces a waveform identical to REQ-027, and that a fresh start at cycle 18 is accepted with tx=1 at cycle 19.
REQ-030 The bench SHALL check that start with len=0 or len=6 leaves tx, busy and done at 0 for 20 cycles.
REQ-031 The bench SHALL check that 'A' with abort=1 at cycle 6 gives tx=0 and busy=0 from cycle 7, with no done pulse through cycle 25.
REQ-032 The bench SHALL check that 'A' with n_rst=0 at cycle 8 gives all outputs 0 from cycle 9, and that a start at the first cycle after n_rst returns to 1 is accepted.
